prio_arb_4: RTL and testbench
=============================

Name: prio_arb_4

Overview:
Four-requester arbiter that shares a single downstream resource, such as a bus port or an encoder-fed datapath, between requesters 0..3. It issues a registered one-hot grant plus an encoded grant index. Two arbitration modes, selectable at run time:
- fixed priority: req[3] highest, req[0] lowest;
- round-robin: rotates from the last granted requester.

A grant is held until the owner releases it, signals done, or exceeds a maximum hold time.

Parameters:
- HOLD_MAX, 15, max consecutive cycles a single grant may stay asserted; 0 disables the limit.
- CW, 4, width of the internal hold counter; must satisfy 2^CW > HOLD_MAX.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- rr_mode  input  1  1 = round-robin, 0 = fixed priority; sampled only at arbitration points
- req  input  4  request vector; req[i] must stay high for the whole transaction of requester i
- done  input  1  owner signals end of transaction; valid only while gnt_v=1
- gnt  output  4  registered one-hot grant; all-zero when idle
- gnt_id  output  2  encoded index of the granted requester; holds last value when gnt_v=0
- gnt_v  output  1  high while any grant is asserted (equals OR of gnt)
- timeout  output  1  one-cycle pulse when a grant is force-released by HOLD_MAX

Behaviour:

Reset:
- rst=1 immediately forces: gnt=0, gnt_id=0, gnt_v=0, timeout=0, state=IDLE, hold counter=0, last_id=3.
- Asserting rst mid-grant drops gnt asynchronously, with no gap cycle.

States: IDLE, GRANT, GAP (2-bit encoding).

IDLE:
- If req != 0, select a winner and go to GRANT.
- gnt, gnt_id and gnt_v are registered, so they are high on the edge after req is first seen. Latency is 1 cycle.
- If req == 0, stay in IDLE.

Winner selection:
- Fixed mode (rr_mode=0): scan 3, 2, 1, 0; first asserted wins.
- Round-robin mode (rr_mode=1): scan (last_id+1), (last_id+2), (last_id+3), last_id, all mod 4, wrapping 3→0.
- last_id updates to the winner when the grant is issued. This happens in both modes.

GRANT:
- The hold counter clears on grant entry and increments each cycle gnt_v=1.
- Release conditions, evaluated each cycle:
  - (a) done=1
  - (b) req[gnt_id]=0
  - (c) HOLD_MAX!=0 and counter == HOLD_MAX-1
- On any release: next state is GAP, and gnt and gnt_v go to 0 on the next edge.
- timeout pulses 1 on that same edge only if (c) holds and neither (a) nor (b) holds. done or a dropped request takes precedence, so there is no timeout in that case.
- Maximum grant duration is exactly HOLD_MAX cycles.

GAP:
- Exactly one cycle with gnt=0 (bus turnaround).
- Arbitration runs in GAP using the current req and rr_mode.
  - If req != 0: GRANT, with the new gnt visible on the next edge. Back-to-back grants are therefore separated by exactly 1 idle cycle.
  - Otherwise: IDLE.
- The same requester may win again if it is the only one requesting, or in fixed mode if it is still the highest requester.

Other rules:
- A request that appears and vanishes while another requester owns the grant is not remembered. There is no request latching.
- done asserted while gnt_v=0 is ignored.
- rr_mode changes during GRANT have no effect until the next arbitration point.
- gnt is always one-hot or zero, never multi-hot.
- gnt_id is the 2-bit encoding of gnt whenever gnt_v=1.

Test Plan:
1. Reset with rst=1 while req=4'b1111 → gnt=0, gnt_v=0, timeout=0. Release rst → gnt=4'b1000, gnt_id=3 one cycle later in fixed mode.
2. Fixed mode, req=4'b0110, done pulsed 3 cycles after grant → gnt=4'b0100, then one gap cycle with gnt=0, then gnt=4'b0100 again because req[2] is still high.
3. Round-robin, req=4'b1111, done pulsed on each grant's 2nd cycle → grant order 0, 1, 2, 3, 0 with one gap cycle between each.
4. HOLD_MAX=15, single req=4'b0001, never done → gnt high exactly 15 cycles, timeout=1 on the falling edge of gnt, then regrant after one gap cycle.
5. On the timeout cycle, done=1 simultaneously → grant released, timeout stays 0.
6. rst asserted mid-grant between clock edges → gnt clears immediately. After release, round-robin restarts from requester 0 (last_id=3).

Source files
------------

// File: rtl/prio_arb_4.sv
// Four-requester arbiter with run-time fixed-priority / round-robin selection,
// a registered one-hot grant, a one-cycle turnaround gap and a hold-time limit.
module prio_arb_4 #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CW       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rr_mode,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_v,
  output logic       timeout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam bit            HOLD_EN   = (HOLD_MAX != 0);
  localparam logic [CW-1:0] HOLD_LAST = HOLD_EN ? CW'(HOLD_MAX - 1) : '0;

  // Fixed priority: requester 3 highest, requester 0 lowest.
  function automatic logic [1:0] fixed_pick(input logic [3:0] r);
    if (r[3])      return 2'd3;
    else if (r[2]) return 2'd2;
    else if (r[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  // Round-robin: rotate the request vector so the requester after last sits
  // at bit 0, take the lowest set bit, then rotate the offset back.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] start;
    logic [1:0] offset;
    dbl   = {r, r};
    start = last + 2'd1;
    rot   = dbl[start +: 4];
    if (rot[0])      offset = 2'd0;
    else if (rot[1]) offset = 2'd1;
    else if (rot[2]) offset = 2'd2;
    else             offset = 2'd3;
    return start + offset;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [1:0]    last_id;
  logic [CW-1:0] hold_cnt;
  logic [1:0]    win;
  logic          take;
  logic          drop;
  logic          timeout_nxt;
  logic          rel_done;
  logic          rel_drop;
  logic          rel_hold;

  assign win      = rr_mode ? rr_pick(req, last_id) : fixed_pick(req);
  assign rel_done = done;
  assign rel_drop = ~req[gnt_id];
  assign rel_hold = HOLD_EN && (hold_cnt == HOLD_LAST);

  // Arbitration happens in both IDLE and GAP; GRANT only watches for release.
  always_comb begin
    state_nxt   = state;
    take        = 1'b0;
    drop        = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (|req) begin
          state_nxt = GRANT;
          take      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_hold) begin
          state_nxt   = GAP;
          drop        = 1'b1;
          timeout_nxt = rel_hold & ~rel_done & ~rel_drop;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered grant stage: outputs change on the edge after the decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= 2'd0;
      gnt_v    <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      last_id  <= 2'd3;
    end else begin
      state   <= state_nxt;
      timeout <= timeout_nxt;
      if (take) begin
        gnt      <= onehot(win);
        gnt_id   <= win;
        gnt_v    <= 1'b1;
        last_id  <= win;
        hold_cnt <= '0;
      end else if (drop) begin
        gnt      <= '0;
        gnt_v    <= 1'b0;
        hold_cnt <= '0;
      end else if (gnt_v) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prio_arb_4.sv
// Bench for prio_arb_4: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level model of owner / hold time / history.
module tb_prio_arb_4;
  localparam int HM = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       rr_mode;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_v;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // Model: current owner (-1 = nobody), cycles the grant has been visible,
  // last winner, last reported id and the expected timeout pulse.
  int m_owner;
  int m_held;
  int m_last;
  int m_id;
  bit m_to;

  prio_arb_4 #(.HOLD_MAX(HM), .CW(4)) dut (
    .clk(clk), .rst(rst), .rr_mode(rr_mode), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_v(gnt_v), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input bit m, input int last);
    if (m) begin
      for (int k = 1; k <= 4; k++) begin
        int i;
        i = (last + k) % 4;
        if (r[i]) return i;
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (r[i]) return i;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 3;
    m_id    = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d, input logic m);
    bit hit_max;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      hit_max = (HM != 0) && (m_held == HM);
      if (d || !r[m_owner] || hit_max) begin
        m_to    = hit_max && !d && r[m_owner];
        m_owner = -1;
      end else begin
        m_held++;
      end
    end else if (r != 4'b0000) begin
      m_owner = pick(r, m, m_last);
      m_last  = m_owner;
      m_id    = m_owner;
      m_held  = 1;
    end
  endtask

  task automatic compare();
    int exp_gnt;
    exp_gnt = (m_owner >= 0) ? (1 << m_owner) : 0;
    check("gnt", gnt, exp_gnt);
    check("gnt_v", gnt_v, (m_owner >= 0) ? 1 : 0);
    check("gnt_id", gnt_id, m_id);
    check("timeout", timeout, m_to);
  endtask

  // One clock: drive inputs, advance the model on the edge, compare just after.
  task automatic cyc(input logic [3:0] r, input logic d, input logic m);
    req     = r;
    done    = d;
    rr_mode = m;
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(r, d, m);
    #1;
    compare();
  endtask

  initial begin
    int ord[5];
    int n;
    logic [3:0] rq;
    logic       md;
    ord = '{0, 1, 2, 3, 0};
    model_reset();
    rst = 1'b1; req = 4'b1111; done = 1'b0; rr_mode = 1'b0;

    // Reset held while everyone requests, then first fixed-priority grant.
    cyc(4'b1111, 1'b0, 1'b0);
    cyc(4'b1111, 1'b0, 1'b0);
    check("t1_rst_gnt", gnt, 0);
    check("t1_rst_gnt_v", gnt_v, 0);
    check("t1_rst_timeout", timeout, 0);
    rst = 1'b0;
    cyc(4'b1111, 1'b0, 1'b0);
    check("t1_first_gnt", gnt, 8);
    check("t1_first_id", gnt_id, 3);
    cyc(4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);

    // Fixed mode, done on the third grant cycle, requester 2 wins again.
    cyc(4'b0110, 1'b0, 1'b0);
    check("t2_gnt", gnt, 4);
    cyc(4'b0110, 1'b0, 1'b0);
    cyc(4'b0110, 1'b1, 1'b0);
    check("t2_gap", gnt, 0);
    cyc(4'b0110, 1'b0, 1'b0);
    check("t2_regrant", gnt, 4);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);

    // Round-robin rotation from a fresh reset.
    rst = 1'b1;
    cyc(4'b0000, 1'b0, 1'b1);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(4'b1111, 1'b0, 1'b1);
      check("t3_order_id", gnt_id, ord[k]);
      check("t3_order_gnt", gnt, 1 << ord[k]);
      cyc(4'b1111, 1'b1, 1'b1);
      check("t3_gap", gnt, 0);
    end
    cyc(4'b0000, 1'b0, 1'b1);

    // Hold limit: a lone requester that never finishes.
    n = 0;
    cyc(4'b0001, 1'b0, 1'b0);
    while (gnt_v && n < 40) begin
      n++;
      cyc(4'b0001, 1'b0, 1'b0);
    end
    check("t4_hold_len", n, 15);
    check("t4_timeout", timeout, 1);
    cyc(4'b0001, 1'b0, 1'b0);
    check("t4_regrant", gnt, 1);
    check("t4_timeout_clear", timeout, 0);

    // done on the limit cycle wins over the timeout.
    for (int k = 0; k < 14; k++) cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0001, 1'b1, 1'b0);
    check("t5_release", gnt, 0);
    check("t5_no_timeout", timeout, 0);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);

    // Asynchronous reset between edges, then round-robin restarts at 0.
    cyc(4'b0010, 1'b0, 1'b1);
    check("t6_pre_gnt", gnt, 2);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_async_gnt", gnt, 0);
    check("t6_async_gnt_v", gnt_v, 0);
    cyc(4'b1111, 1'b0, 1'b1);
    rst = 1'b0;
    cyc(4'b1111, 1'b0, 1'b1);
    check("t6_rr_restart", gnt, 1);

    // Randomized traffic with sticky requests and occasional resets.
    rq = 4'b0000;
    md = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
      end
      if ($urandom_range(0, 24) == 0) md = ~md;
      if ($urandom_range(0, 399) == 0) rst = 1'b1;
      cyc(rq, ($urandom_range(0, 9) == 0), md);
      rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
